// File: rtl/noc_output_port_arbiter.sv
// Round-robin output-link arbiter with wormhole locking, a one-stage output
// register and a starvation watchdog that force-releases a stalled lock.
module noc_output_port_arbiter #(
    parameter int NUM_IN  = 5,
    parameter int FLIT_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                     noc_clk,
    input  logic                     noc_rst,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN-1:0]        in_head,
    input  logic [NUM_IN-1:0]        in_tail,
    input  logic [NUM_IN*FLIT_W-1:0] in_flit,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [FLIT_W-1:0]        out_flit,
    input  logic                     out_ready,
    output logic [NUM_IN-1:0]        grant,
    output logic                     locked,
    output logic                     timeout_pulse,
    output logic                     proto_err
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Handshake: a flit moves on input i when in_valid[i] && in_ready[i];
    // downstream takes out_flit when out_valid && out_ready.
    logic [0:0]        r_state;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;
    logic              r_timeout;
    logic              r_proto_err;

    logic              w_load_en;
    logic [NUM_IN-1:0] w_cand;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W-1:0]  w_winner;
    logic              w_win_found;
    logic [PTR_W-1:0]  w_sel;
    logic              w_sel_ok;
    logic              w_xfer;
    logic [FLIT_W-1:0] w_sel_flit;
    logic              w_sel_head;
    logic              w_sel_tail;
    logic              w_owner_valid;
    logic              w_expire;
    logic              w_proto;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_cand    = in_valid & in_head;

    // Search starts just after the last-served port so every port gets a turn.
    always_comb begin
        w_idx       = r_rr_ptr;
        w_winner    = '0;
        w_win_found = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_idx = (w_idx == PTR_W'(NUM_IN - 1)) ? '0 : w_idx + PTR_W'(1);
            if (!w_win_found && w_cand[w_idx]) begin
                w_win_found = 1'b1;
                w_winner    = w_idx;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (r_state == ST_IDLE) begin
            w_sel    = w_winner;
            w_sel_ok = w_win_found;
        end else begin
            w_sel    = r_owner;
            w_sel_ok = 1'b1;
        end
        if (w_sel_ok) begin
            in_ready[w_sel] = w_load_en;
        end
    end

    assign w_xfer        = w_sel_ok && w_load_en && in_valid[w_sel];
    assign w_sel_flit    = in_flit[int'(w_sel)*FLIT_W +: FLIT_W];
    assign w_sel_head    = in_head[w_sel];
    assign w_sel_tail    = in_tail[w_sel];
    assign w_owner_valid = in_valid[r_owner];

    // A transfer in the expiry cycle wins over the watchdog.
    assign w_expire = (TIMEOUT != 0) && (r_state == ST_LOCKED) && !w_xfer
                      && (r_cnt >= TIMEOUT_C);

    assign w_proto = (r_state == ST_IDLE) ? |(in_valid & ~in_head)
                                          : (w_xfer && w_sel_head);

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= PTR_W'(NUM_IN - 1);
            r_owner     <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_timeout   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_timeout   <= w_expire;
            r_proto_err <= w_proto;
            if (w_load_en) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_flit <= w_sel_flit;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        if (w_sel_tail) begin
                            r_rr_ptr <= w_sel;
                        end else begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_sel;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer) begin
                        r_cnt <= '0;
                        if (w_sel_tail) begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= r_owner;
                        end
                    end else if (w_expire) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= r_owner;
                        r_cnt    <= '0;
                    end else if (!w_owner_valid && (r_cnt != CNT_MAX)) begin
                        // Only an absent owner counts; backpressure does not.
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        grant = '0;
        if (r_state == ST_LOCKED) begin
            grant[r_owner] = 1'b1;
        end
    end

    assign locked        = (r_state == ST_LOCKED);
    assign out_valid     = r_out_valid;
    assign out_flit      = r_out_flit;
    assign timeout_pulse = r_timeout;
    assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Bench for noc_output_port_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model and an output flit queue.
module tb_noc_output_port_arbiter;

  localparam int N  = 5;
  localparam int W  = 32;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           noc_rst;
  logic [N-1:0]   in_valid, in_head, in_tail, in_ready, grant;
  logic [N*W-1:0] in_flit;
  logic           out_valid, out_ready, locked, timeout_pulse, proto_err;
  logic [W-1:0]   out_flit;

  noc_output_port_arbiter #(.NUM_IN(N), .FLIT_W(W), .TIMEOUT(TO), .CNT_W(8)) dut (
    .noc_clk(clk), .noc_rst(noc_rst),
    .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail), .in_flit(in_flit),
    .in_ready(in_ready), .out_valid(out_valid), .out_flit(out_flit),
    .out_ready(out_ready), .grant(grant), .locked(locked),
    .timeout_pulse(timeout_pulse), .proto_err(proto_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_owner;   // -1 when no packet holds the link
  int           m_last;    // port served most recently
  int           m_cnt;     // cycles the owner has been absent
  bit           m_ov;
  logic [W-1:0] m_of;
  bit           m_tp, m_pe;
  int           m_xfer, m_to_port;
  logic [W-1:0] exp_q[$];

  logic [N-1:0]   d_valid, d_head, d_tail;
  logic [N*W-1:0] d_flit;
  logic           d_oready, d_rst;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_cnt = 0;
    m_ov = 0; m_of = '0; m_tp = 0; m_pe = 0;
    m_xfer = -1; m_to_port = -1;
    exp_q.delete();
  endtask

  // One clock cycle: drive, check combinational ready and downstream data,
  // advance the model, then check every registered output after the edge.
  task automatic step();
    bit           le;
    int           sel;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_g;
    bit           nxt_pe;
    logic [W-1:0] fl;
    noc_rst   = d_rst;
    in_valid  = d_valid;
    in_head   = d_head;
    in_tail   = d_tail;
    in_flit   = d_flit;
    out_ready = d_oready;
    #2;
    m_xfer = -1; m_to_port = -1;
    if (!d_rst) begin
      le  = !m_ov || d_oready;
      sel = -1;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (sel < 0 && d_valid[(m_last + k) % N] && d_head[(m_last + k) % N])
            sel = (m_last + k) % N;
        end
      end else begin
        sel = m_owner;
      end
      exp_rdy = '0;
      if (sel >= 0 && le) exp_rdy[sel] = 1'b1;
      check_eq("in_ready", in_ready, exp_rdy);
      if (out_valid && d_oready) begin
        check_eq("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check_eq("sb_flit", out_flit, exp_q.pop_front());
      end
      if (sel >= 0 && le && d_valid[sel]) m_xfer = sel;
      nxt_pe = (m_owner < 0) ? |(d_valid & ~d_head) : (m_xfer >= 0 && d_head[m_xfer]);
      m_tp = 0;
      if (m_xfer >= 0) begin
        fl = d_flit[m_xfer*W +: W];
        exp_q.push_back(fl);
      end
      if (le) begin
        m_ov = (m_xfer >= 0);
        if (m_xfer >= 0) m_of = fl;
      end
      if (m_owner < 0) begin
        if (m_xfer >= 0) begin
          if (d_tail[m_xfer]) m_last = m_xfer;
          else begin m_owner = m_xfer; m_cnt = 0; end
        end
      end else if (m_xfer >= 0) begin
        m_cnt = 0;
        if (d_tail[m_xfer]) begin m_last = m_owner; m_owner = -1; end
      end else if (m_cnt >= TO) begin
        m_tp = 1; m_to_port = m_owner; m_last = m_owner; m_owner = -1; m_cnt = 0;
      end else if (!d_valid[m_owner]) begin
        m_cnt++;
      end
      m_pe = nxt_pe;
    end
    @(posedge clk);
    #1;
    if (d_rst) model_reset();
    exp_g = '0;
    if (m_owner >= 0) exp_g[m_owner] = 1'b1;
    check_eq("out_valid", out_valid, m_ov);
    check_eq("out_flit", out_flit, m_of);
    check_eq("grant", grant, exp_g);
    check_eq("locked", locked, m_owner >= 0);
    check_eq("timeout_pulse", timeout_pulse, m_tp);
    check_eq("proto_err", proto_err, m_pe);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    d_valid = '0; d_head = '0; d_tail = '0; d_flit = '0; d_oready = 1'b1; d_rst = 1'b0;
  endtask

  task automatic set_port(input int p, input bit v, input bit h, input bit t, input logic [W-1:0] data);
    d_valid[p] = v; d_head[p] = h; d_tail[p] = t; d_flit[p*W +: W] = data;
  endtask

  task automatic do_reset();
    clear_inputs();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int           rem[N];
  int           stall[N];
  bit           cur_h[N], cur_t[N];
  logic [W-1:0] cur_d[N];
  logic [W-1:0] got_q[$];
  logic [W-1:0] held;
  int           idx3[N];
  int           waited;
  bit           seen;

  initial begin
    model_reset();
    clear_inputs();
    noc_rst = 1'b1; in_valid = '0; in_head = '0; in_tail = '0; in_flit = '0; out_ready = 1'b1;

    // Reset values, then one single-flit packet on port 0
    do_reset();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_flit", out_flit, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_locked", locked, 0);
    set_port(0, 1, 1, 1, 32'hA5);
    step();
    check_eq("single_valid", out_valid, 1);
    check_eq("single_flit", out_flit, 32'hA5);
    check_eq("single_locked", locked, 0);
    clear_inputs();
    step();

    // Three 3-flit packets on ports 0, 2, 4 served without interleaving
    do_reset();
    got_q.delete();
    seen = 0;
    for (int p = 0; p < N; p++) idx3[p] = 0;
    for (int c = 0; c < 40 && got_q.size() < 9; c++) begin
      for (int p = 0; p < N; p += 2)
        set_port(p, idx3[p] < 3, idx3[p] == 0, idx3[p] == 2, 32'h100 * p + idx3[p]);
      step();
      if (m_xfer >= 0) idx3[m_xfer]++;
      if (out_valid) got_q.push_back(out_flit);
      if (got_q.size() == 1 && !seen) begin
        check_eq("wormhole_grant0", grant, 5'b00001);
        seen = 1;
      end
    end
    check_eq("wormhole_count", got_q.size(), 9);
    for (int i = 0; i < 9 && i < got_q.size(); i++)
      check_eq("wormhole_order", got_q[i], 32'h100 * (2 * (i / 3)) + (i % 3));
    clear_inputs();
    step();

    // Backpressure mid-packet holds data and never trips the watchdog
    do_reset();
    set_port(1, 1, 1, 0, 32'hB0);
    step();
    held = 32'hB0;
    set_port(1, 1, 0, 0, 32'hB1);
    d_oready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      check_eq("bp_hold_flit", out_flit, held);
      check_eq("bp_locked", locked, 1);
    end
    d_oready = 1'b1;
    for (int f = 1; f < 4; f++) begin
      set_port(1, 1, 0, f == 3, 32'hB0 + f);
      step();
    end
    clear_inputs();
    step();
    check_eq("bp_tail_flit", out_flit, 32'hB3);
    check_eq("bp_released", locked, 0);

    // Watchdog: port 1 abandons its packet while port 3 waits with a head
    do_reset();
    set_port(1, 1, 1, 0, 32'hC1);
    step();
    set_port(1, 0, 0, 0, 32'h0);
    set_port(3, 1, 1, 0, 32'hD3);
    waited = 0;
    while (!timeout_pulse && waited < 30) begin
      step();
      waited++;
    end
    check_eq("wd_cycles", waited, TO + 1);
    check_eq("wd_unlocked", locked, 0);
    step();
    check_eq("wd_next_grant", grant, 5'b01000);
    check_eq("wd_pulse_once", timeout_pulse, 0);
    clear_inputs();

    // Body flit on port 2 while idle
    do_reset();
    set_port(2, 1, 0, 0, 32'hE2);
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("body_idle_err", proto_err, 1);
      check_eq("body_idle_noout", out_valid, 0);
    end
    clear_inputs();
    step();
    check_eq("body_idle_clear", proto_err, 0);

    // Reset in the middle of a locked packet
    do_reset();
    set_port(1, 1, 1, 0, 32'hF0);
    step();
    set_port(1, 1, 0, 0, 32'hF1);
    step();
    set_port(1, 1, 0, 0, 32'hF2);
    set_port(0, 1, 1, 0, 32'hA0);
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_locked", locked, 0);
    check_eq("mid_rst_grant", grant, 0);
    step();
    check_eq("post_rst_grant", grant, 5'b00001);

    // Randomized traffic with stalls, protocol errors and occasional resets
    do_reset();
    for (int p = 0; p < N; p++) begin rem[p] = 0; stall[p] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < N; p++) begin
        if (rem[p] == 0) begin
          rem[p]   = $urandom_range(1, 4);
          cur_h[p] = 1; cur_t[p] = (rem[p] == 1); cur_d[p] = $urandom;
        end
        if (stall[p] == 0 && $urandom_range(0, 99) < 3) stall[p] = $urandom_range(5, 14);
        if (stall[p] > 0) begin
          stall[p]--;
          set_port(p, 0, cur_h[p], cur_t[p], cur_d[p]);
        end else begin
          set_port(p, $urandom_range(0, 99) < 70,
                   cur_h[p] ^ ($urandom_range(0, 99) < 2), cur_t[p], cur_d[p]);
        end
      end
      d_oready = ($urandom_range(0, 99) < 75);
      d_rst    = ($urandom_range(0, 999) < 3);
      step();
      if (d_rst) begin
        for (int p = 0; p < N; p++) rem[p] = 0;
      end else begin
        if (m_xfer >= 0) begin
          rem[m_xfer]--;
          if (rem[m_xfer] > 0) begin
            cur_h[m_xfer] = 0; cur_t[m_xfer] = (rem[m_xfer] == 1); cur_d[m_xfer] = $urandom;
          end
        end
        if (m_to_port >= 0) rem[m_to_port] = 0;
      end
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_output_port_arbiter.md
Name: noc_output_port_arbiter

Overview:
- Shares one router output link between NUM_IN input ports (order: east, west, south, north, local) using round-robin arbitration with wormhole locking.
- Sits between the input buffers and each sender-side output link of the position mux; one instance per output direction.
- Holds a packet's grant from head flit to tail flit.
- Registers the outgoing flit in a single stage and releases a stalled lock with a watchdog.

Parameters:
- NUM_IN, 5, number of requesting input ports; index 0 = east … 4 = local.
- FLIT_W, 32, flit payload width in bits.
- TIMEOUT, 64, idle cycles an owner may starve a locked link before forced release; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- noc_clk  in  1  sole clock; all state updates on rising edge.
- noc_rst  in  1  synchronous reset, active-high.
- in_valid  in  NUM_IN  per-port flit valid.
- in_head  in  NUM_IN  per-port head-flit marker, qualified by in_valid.
- in_tail  in  NUM_IN  per-port tail-flit marker; head&tail means a single-flit packet.
- in_flit  in  NUM_IN*FLIT_W  per-port flit; port i occupies bits [i*FLIT_W +: FLIT_W].
- in_ready  out  NUM_IN  per-port accept; combinational.
- out_valid  out  1  registered output flit valid.
- out_flit  out  FLIT_W  registered output flit.
- out_ready  in  1  downstream accept.
- grant  out  NUM_IN  one-hot current owner while LOCKED; 0 in IDLE.
- locked  out  1  high in LOCKED state.
- timeout_pulse  out  1  one-cycle pulse on forced release.
- proto_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset values (noc_rst=1 at an edge):
  - out_valid=0, out_flit=0, grant=0, locked=0, timeout_pulse=0, proto_err=0.
  - state=IDLE, rr_ptr=NUM_IN-1 (port 0 wins first), watchdog count=0.
- Reset mid-packet drops the lock and any held output flit. No partial flit is emitted afterwards.
- load_en = !out_valid || out_ready. The output register loads only when load_en=1.
  - The output register holds out_flit stable while out_valid && !out_ready.
  - out_valid drops after a transfer if nothing is loaded that cycle.
- Transfer on input i occurs when in_valid[i] && in_ready[i]. The flit appears on out_flit/out_valid the next cycle, so latency is 1 cycle.
- IDLE:
  - Candidates are ports with in_valid & in_head.
  - winner = first candidate searching rr_ptr+1, rr_ptr+2, … modulo NUM_IN.
  - in_ready[winner] = load_en; all other in_ready = 0.
  - If the winner transfers with in_tail=1: stay IDLE, rr_ptr <= winner.
  - If the winner transfers with in_tail=0: go LOCKED, owner <= winner, count <= 0.
  - If load_en=0: no transfer and no state change. The winner is recomputed next cycle, so a newly arriving lower-index head may win. This is allowed because no grant is committed before transfer.
  - A valid non-head flit on any port in IDLE is not accepted and pulses proto_err once per cycle it is present.
- LOCKED:
  - in_ready[owner] = load_en; all others = 0. grant = onehot(owner), locked = 1.
  - On an owner transfer, count <= 0.
  - On an owner transfer with in_tail=1: go IDLE, rr_ptr <= owner.
  - An owner transfer with in_head=1 (a new head before the tail) is still forwarded and pulses proto_err. The lock is kept.
  - If in_valid[owner]=0, count increments by 1, saturating. Cycles where in_valid[owner]=1 but load_en=0 do not count, because backpressure is not starvation.
  - When TIMEOUT≠0 and count reaches TIMEOUT: go IDLE next cycle, timeout_pulse=1 for one cycle, rr_ptr <= owner, count <= 0. No flit is emitted for the truncated packet.
- Simultaneous head on all ports: service order is round-robin. Each port gets one packet before any port is served twice.
- A watchdog expiry and an owner transfer in the same cycle: the transfer wins, count resets and no timeout fires.

Test Plan:
- Reset, then in_valid=5'b00001 head+tail flit 0xA5 -> in_ready[0]=1 the same cycle; out_valid=1, out_flit=0xA5 the next cycle; locked stays 0.
- Ports 0,2,4 each hold 3-flit packets (head, body, tail), out_ready=1 -> output sequence is 0's three flits, then 2's, then 4's, contiguous with no interleaving; grant=5'b00001 while port 0 is locked.
- out_ready=0 for 4 cycles mid-packet -> out_flit stable, owner in_ready=0, no timeout even with TIMEOUT=2; the flow resumes in order.
- TIMEOUT=8: port 1 sends a head without a tail, then in_valid[1]=0 -> after 8 idle cycles timeout_pulse=1 for one cycle, locked=0, and a pending port 3 head is granted next.
- Body flit on port 2 while IDLE -> in_ready[2]=0, proto_err=1 for each cycle it is held, out_valid stays 0.
- Assert noc_rst during a locked 4-flit packet after flit 2 -> next cycle out_valid=0, locked=0, grant=0; the first grant after release goes to port 0 if it is requesting.
